// File: rtl/jtag_types_pkg.sv
// Shared JTAG TAP types: the 16-state TAP encoding and the default IR opcodes.
package jtag_types_pkg;

   // Standard 1149.1 state encoding; TLR = all ones so a stuck-high bus reads as reset.
   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PAU_DR = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PAU_IR = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } tap_state_t;

   localparam int unsigned IR_WIDTH_DEF   = 5;
   localparam logic [4:0]  IR_CAPTURE_DEF = 5'b00001;
   localparam logic [4:0]  OPC_IDCODE_DEF = 5'b00001;
   localparam logic [4:0]  OPC_SAMPLE_DEF = 5'b00010;
   localparam logic [4:0]  OPC_EXTEST_DEF = 5'b00000;

endpackage

// File: rtl/tap_ctrl_if.sv
// Bundle between the TAP controller and the data-register chain.
interface tap_ctrl_if
   import jtag_types_pkg::*;
#(
   parameter int unsigned IR_WIDTH = IR_WIDTH_DEF
);
   tap_state_t          tap_state;
   logic [IR_WIDTH-1:0] instr;
   logic                tap_reset;
   logic                dr_capture;
   logic                dr_shift;
   logic                dr_update;
   logic                run_idle;
   logic                sel_bypass;
   logic                sel_idcode;
   logic                sel_sample;
   logic                sel_extest;

   modport ctrl (
      output tap_state, instr, tap_reset, dr_capture, dr_shift, dr_update, run_idle,
      output sel_bypass, sel_idcode, sel_sample, sel_extest
   );
   modport dr (
      input tap_state, instr, tap_reset, dr_capture, dr_shift, dr_update, run_idle,
      input sel_bypass, sel_idcode, sel_sample, sel_extest
   );
endinterface

// File: rtl/tap_fsm.sv
// 16-state TAP state machine with combinational strobe decodes of the current state.
module tap_fsm
   import jtag_types_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tms,
   output tap_state_t state,
   output logic       tap_reset,
   output logic       run_idle,
   output logic       dr_capture,
   output logic       dr_shift,
   output logic       dr_update,
   output logic       ir_capture,
   output logic       ir_shift,
   output logic       ir_update
);

   tap_state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= TLR;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   assign state      = state_q;
   assign tap_reset  = (state_q == TLR);
   assign run_idle   = (state_q == RTI);
   assign dr_capture = (state_q == CAP_DR);
   assign dr_shift   = (state_q == SH_DR);
   assign dr_update  = (state_q == UPD_DR);
   assign ir_capture = (state_q == CAP_IR);
   assign ir_shift   = (state_q == SH_IR);
   assign ir_update  = (state_q == UPD_IR);

endmodule

// File: rtl/tap_ctrl_ir.sv
// JTAG TAP controller top: FSM, instruction shift/update registers and DR select decode.
module tap_ctrl_ir
   import jtag_types_pkg::*;
#(
   parameter int unsigned         IR_WIDTH   = IR_WIDTH_DEF,
   parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_DEF),
   parameter logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(OPC_IDCODE_DEF),
   parameter logic [IR_WIDTH-1:0] OPC_SAMPLE = IR_WIDTH'(OPC_SAMPLE_DEF),
   parameter logic [IR_WIDTH-1:0] OPC_EXTEST = IR_WIDTH'(OPC_EXTEST_DEF),
   parameter logic [IR_WIDTH-1:0] OPC_BYPASS = '1
) (
   input  logic                TCK,
   input  logic                nTRST,
   input  logic                TMS,
   input  logic                TDI,
   output tap_state_t          tap_state,
   output logic                ir_tdo,
   output logic [IR_WIDTH-1:0] instr,
   output logic                tap_reset,
   output logic                ir_capture,
   output logic                ir_shift,
   output logic                ir_update,
   output logic                dr_capture,
   output logic                dr_shift,
   output logic                dr_update,
   output logic                run_idle,
   output logic                sel_bypass,
   output logic                sel_idcode,
   output logic                sel_sample,
   output logic                sel_extest
);

   logic [IR_WIDTH-1:0] ir_shreg_q, ir_shreg_d;
   logic [IR_WIDTH-1:0] instr_q, instr_d;

   tap_fsm u_fsm (
      .clk        (TCK),
      .rst_n      (nTRST),
      .tms        (TMS),
      .state      (tap_state),
      .tap_reset  (tap_reset),
      .run_idle   (run_idle),
      .dr_capture (dr_capture),
      .dr_shift   (dr_shift),
      .dr_update  (dr_update),
      .ir_capture (ir_capture),
      .ir_shift   (ir_shift),
      .ir_update  (ir_update)
   );

   // LSB leaves on ir_tdo first; Pause/Exit states simply hold the partial shift.
   always_comb begin
      ir_shreg_d = ir_shreg_q;
      case (tap_state)
         CAP_IR:  ir_shreg_d = IR_CAPTURE;
         SH_IR:   ir_shreg_d = {TDI, ir_shreg_q[IR_WIDTH-1:1]};
         default: ir_shreg_d = ir_shreg_q;
      endcase
   end

   always_comb begin
      instr_d = instr_q;
      if (tap_state == UPD_IR)   instr_d = ir_shreg_q;
      else if (tap_state == TLR) instr_d = OPC_IDCODE;
   end

   always_ff @(posedge TCK) begin
      if (!nTRST) begin
         ir_shreg_q <= IR_CAPTURE;
         instr_q    <= OPC_IDCODE;
      end else begin
         ir_shreg_q <= ir_shreg_d;
         instr_q    <= instr_d;
      end
   end

   // Priority chain guarantees exactly one select even if opcodes collide.
   always_comb begin
      sel_bypass = 1'b0;
      sel_idcode = 1'b0;
      sel_sample = 1'b0;
      sel_extest = 1'b0;
      if (instr_q == OPC_IDCODE)      sel_idcode = 1'b1;
      else if (instr_q == OPC_SAMPLE) sel_sample = 1'b1;
      else if (instr_q == OPC_EXTEST) sel_extest = 1'b1;
      else                            sel_bypass = 1'b1;
   end

   assign ir_tdo = ir_shreg_q[0];
   assign instr  = instr_q;

endmodule

// File: tb/tb_tap_ctrl_ir.sv
// Directed bench for tap_ctrl_ir: state-walk vector table plus IR load sequences.
module tb_tap_ctrl_ir;
   import jtag_types_pkg::*;

   logic       TCK = 1'b0;
   logic       nTRST, TMS, TDI;
   tap_state_t tap_state;
   logic       ir_tdo;
   logic [4:0] instr;
   logic       tap_reset, ir_capture, ir_shift, ir_update;
   logic       dr_capture, dr_shift, dr_update, run_idle;
   logic       sel_bypass, sel_idcode, sel_sample, sel_extest;

   int n_cmp = 0;
   int n_err = 0;

   tap_ctrl_ir dut (
      .TCK(TCK), .nTRST(nTRST), .TMS(TMS), .TDI(TDI),
      .tap_state(tap_state), .ir_tdo(ir_tdo), .instr(instr),
      .tap_reset(tap_reset), .ir_capture(ir_capture), .ir_shift(ir_shift), .ir_update(ir_update),
      .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update), .run_idle(run_idle),
      .sel_bypass(sel_bypass), .sel_idcode(sel_idcode), .sel_sample(sel_sample), .sel_extest(sel_extest)
   );

   always #5 TCK = ~TCK;

   typedef struct {
      logic       tms;
      tap_state_t nxt;
   } vec_t;

   vec_t vecs[44];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic tms_i, input logic tdi_i);
      TMS = tms_i;
      TDI = tdi_i;
      @(posedge TCK);
      #1;
   endtask

   // {tap_reset, run_idle, dr_cap, dr_sh, dr_upd, ir_cap, ir_sh, ir_upd}
   function automatic logic [7:0] strobe_exp(input tap_state_t s);
      case (s)
         TLR:     return 8'b1000_0000;
         RTI:     return 8'b0100_0000;
         CAP_DR:  return 8'b0010_0000;
         SH_DR:   return 8'b0001_0000;
         UPD_DR:  return 8'b0000_1000;
         CAP_IR:  return 8'b0000_0100;
         SH_IR:   return 8'b0000_0010;
         UPD_IR:  return 8'b0000_0001;
         default: return 8'b0000_0000;
      endcase
   endfunction

   function automatic logic [7:0] strobes();
      return {tap_reset, run_idle, dr_capture, dr_shift, dr_update, ir_capture, ir_shift, ir_update};
   endfunction

   function automatic logic [3:0] sels();
      return {sel_bypass, sel_idcode, sel_sample, sel_extest};
   endfunction

   // From RTI: enter SH_IR, shift opc LSB first (TMS=1 on last bit), then UPD_IR -> RTI.
   task automatic load_ir(input logic [4:0] opc);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 5; i++) step(i == 4, opc[i]);
      step(1, 0); step(0, 0);
   endtask

   initial begin
      vecs = '{
         '{1, TLR},    '{0, RTI},    '{0, RTI},    '{1, SEL_DR},
         '{0, CAP_DR}, '{0, SH_DR},  '{0, SH_DR},  '{1, EX1_DR},
         '{0, PAU_DR}, '{0, PAU_DR}, '{1, EX2_DR}, '{0, SH_DR},
         '{1, EX1_DR}, '{1, UPD_DR}, '{0, RTI},    '{1, SEL_DR},
         '{0, CAP_DR}, '{1, EX1_DR}, '{0, PAU_DR}, '{1, EX2_DR},
         '{1, UPD_DR}, '{1, SEL_DR}, '{1, SEL_IR}, '{0, CAP_IR},
         '{0, SH_IR},  '{0, SH_IR},  '{1, EX1_IR}, '{0, PAU_IR},
         '{0, PAU_IR}, '{1, EX2_IR}, '{0, SH_IR},  '{1, EX1_IR},
         '{1, UPD_IR}, '{0, RTI},    '{1, SEL_DR}, '{1, SEL_IR},
         '{0, CAP_IR}, '{1, EX1_IR}, '{0, PAU_IR}, '{1, EX2_IR},
         '{1, UPD_IR}, '{1, SEL_DR}, '{1, SEL_IR}, '{1, TLR}
      };

      nTRST = 1'b0; TMS = 1'b0; TDI = 1'b0;
      #2;
      step(0, 0);
      nTRST = 1'b1;
      chk("rst_state",   tap_state, TLR);
      chk("rst_instr",   instr, 5'b00001);
      chk("rst_strobes", strobes(), 8'b1000_0000);
      chk("rst_sels",    sels(), 4'b0100);
      chk("rst_tdo",     ir_tdo, 1'b1);

      // Full transition walk starting in TLR.
      for (int i = 0; i < 44; i++) begin
         step(vecs[i].tms, 0);
         chk($sformatf("walk_state[%0d]", i), tap_state, vecs[i].nxt);
         chk($sformatf("walk_strobe[%0d]", i), strobes(), strobe_exp(vecs[i].nxt));
      end

      // nTRST from SH_DR, with TMS=0 trying to stay in shift.
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      chk("pre_trst_state", tap_state, SH_DR);
      nTRST = 1'b0;
      step(0, 0);
      nTRST = 1'b1;
      chk("trst_state",   tap_state, TLR);
      chk("trst_instr",   instr, 5'b00001);
      chk("trst_idcode",  sel_idcode, 1'b1);
      chk("trst_reset",   tap_reset, 1'b1);

      // Five TMS=1 from RTI and from PAU_IR (the longest path).
      step(0, 0);
      chk("to_rti", tap_state, RTI);
      step(1, 0); chk("tms1_e1", tap_state, SEL_DR);
      step(1, 0); chk("tms1_e2", tap_state, SEL_IR);
      step(1, 0); step(1, 0); step(1, 0);
      chk("tms1_e5", tap_state, TLR);
      step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0);
      chk("at_pau_ir", tap_state, PAU_IR);
      for (int i = 0; i < 4; i++) step(1, 0);
      chk("pau_ir_4", tap_state, SEL_IR);
      step(1, 0);
      chk("pau_ir_5", tap_state, TLR);
      step(0, 0);

      // BYPASS load with ir_tdo observed before each shift edge.
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      chk("byp_sh_ir", tap_state, SH_IR);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("byp_tdo[%0d]", i), ir_tdo, (i == 0) ? 1'b1 : 1'b0);
         chk($sformatf("byp_hold[%0d]", i), instr, 5'b00001);
         step(i == 4, 1);
      end
      step(1, 0);
      chk("byp_upd_state", tap_state, UPD_IR);
      chk("byp_upd_instr", instr, 5'b00001);
      step(0, 0);
      chk("byp_instr", instr, 5'b11111);
      chk("byp_sels",  sels(), 4'b1000);

      // SAMPLE (bits 0,1,0,0,0 LSB first) with a PAU_IR detour after two bits.
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      step(0, 0); step(1, 1);
      chk("smp_ex1", tap_state, EX1_IR);
      chk("smp_sh2", dut.ir_shreg_q, 5'b10000);
      step(0, 0);
      chk("smp_pau", tap_state, PAU_IR);
      step(0, 1); step(0, 1);
      chk("smp_pau_hold", dut.ir_shreg_q, 5'b10000);
      step(1, 1);
      chk("smp_ex2_hold", dut.ir_shreg_q, 5'b10000);
      step(0, 1);
      chk("smp_resume", tap_state, SH_IR);
      chk("smp_no_recap", dut.ir_shreg_q, 5'b10000);
      step(0, 0); step(0, 0); step(1, 0);
      chk("smp_sh5", dut.ir_shreg_q, 5'b00010);
      step(1, 0); step(0, 0);
      chk("smp_instr", instr, 5'b00010);
      chk("smp_sels",  sels(), 4'b0010);

      load_ir(5'b10101);
      chk("undef_instr", instr, 5'b10101);
      chk("undef_sels",  sels(), 4'b1000);
      load_ir(5'b00000);
      chk("extest_sels", sels(), 4'b0001);
      load_ir(5'b00001);
      chk("idcode_sels", sels(), 4'b0100);

      // Reaching TLR via TMS reloads IDCODE over a loaded instruction.
      load_ir(5'b00010);
      chk("pre_tlr_sels", sels(), 4'b0010);
      step(1, 0); step(1, 0); step(1, 0); step(0, 0);
      chk("tlr_reload", instr, 5'b00001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
